default_slave_wr: RTL
=====================

DEFAULT_SLAVE_WR -- requirements
Module: default_slave_wr

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 SHALL provide ports (name direction width meaning):
  ACLK        in   1  bus clock, all state on rising edge
  ARESET      in   1  synchronous active-high reset
  AWID_SD     in   8  write address ID (slave-side ID width)
  AWLEN_SD    in   4  burst length minus one
  AWVALID_SD  in   1  address valid
  AWREADY_SD  out  1  address ready
  WLAST_SD    in   1  last data beat
  WVALID_SD   in   1  data valid (W channel decode-miss output)
  WREADY_SD   out  1  data ready
  BID_SD      out  8  response ID
  BRESP_SD    out  2  write response
  BVALID_SD   out  1  response valid
  BREADY_SD   in   1  response ready
  LEN_ERR_SD  out  1  one-cycle pulse, beat count differed from AWLEN_SD+1
REQ-003 SHALL drive BRESP_SD constant 2'b11 (DECERR); no data or strobe inputs exist, all write data is discarded.

Function
REQ-004 SHALL implement a three-state FSM: IDLE, DATA, RESP; state is registered, AWREADY_SD/WREADY_SD/BVALID_SD decode from state only (Moore, no input-to-output path).
REQ-005 SHALL assert AWREADY_SD = 1 only in IDLE, WREADY_SD = 1 only in DATA, BVALID_SD = 1 only in RESP.
REQ-006 IDLE: on AWVALID_SD & AWREADY_SD SHALL latch AWID_SD into id_q, AWLEN_SD into len_q, clear beat counter to 0, and enter DATA next cycle.
REQ-007 DATA: each cycle with WVALID_SD & WREADY_SD SHALL count one beat; counter 5 bits, saturates at 31 (no wrap).
REQ-008 DATA: accepted beat with WLAST_SD = 1 SHALL end the burst -> RESP next cycle; WLAST_SD is the only terminator (beats beyond AWLEN_SD+1 keep being absorbed).
REQ-009 On the terminating beat, if (counter+1) != len_q+1 SHALL pulse LEN_ERR_SD high for exactly the following cycle; otherwise LEN_ERR_SD stays 0.
REQ-010 DATA with WVALID_SD = 0 SHALL hold state and counter; no timeout.
REQ-011 RESP: BID_SD = id_q, BVALID_SD = 1 held stable until BREADY_SD = 1; on BVALID_SD & BREADY_SD SHALL enter IDLE next cycle.
REQ-012 BID_SD SHALL hold id_q in all states (changes only on AW handshake); BRESP_SD = 2'b11 in all states.
REQ-013 Back-to-back: after B handshake, earliest next AW handshake is the cycle after (one IDLE cycle minimum); min transaction = 3 cycles for single beat with always-ready environment.
REQ-014 AWVALID_SD asserted in DATA or RESP SHALL be ignored (AWREADY_SD = 0) and remain pending to IDLE.
REQ-015 WVALID_SD asserted in IDLE or RESP SHALL not be counted (WREADY_SD = 0).
REQ-016 Only one outstanding write; no ID reordering or queuing.

Reset
REQ-017 ARESET = 1 at a rising edge SHALL force state = IDLE, id_q = 0, len_q = 0, counter = 0, LEN_ERR_SD = 0 on the next cycle, regardless of current state.
REQ-018 Post-reset outputs: AWREADY_SD = 1, WREADY_SD = 0, BVALID_SD = 0, BID_SD = 8'h00, BRESP_SD = 2'b11, LEN_ERR_SD = 0.
REQ-019 Reset mid-burst or during RESP SHALL abandon the transaction; no B response is issued for it.

Verification
REQ-020 Single beat: AWID=8'h25, AWLEN=0, one WVALID+WLAST beat, BREADY=1 -> BVALID one cycle after last beat, BID=8'h25, BRESP=2'b11, LEN_ERR_SD=0, back in IDLE.
REQ-021 4-beat burst with WVALID gaps: AWLEN=3, beats at cycles 1,3,4,7 WLAST on 4th -> counter holds across gaps, exactly one B, LEN_ERR_SD=0.
REQ-022 Length mismatch: AWLEN=3, WLAST on 2nd beat -> RESP entered, LEN_ERR_SD one-cycle pulse; AWLEN=0 with WLAST on 3rd beat -> all 3 beats accepted, pulse.
REQ-023 B backpressure: BREADY=0 for 5 cycles -> BVALID=1, BID stable, AWREADY=0 throughout, pending AW (AWID=8'h7A) accepted one cycle after B handshake.
REQ-024 Reset in DATA after 2 of 4 beats -> next cycle IDLE, AWREADY=1, BVALID=0, BID=8'h00, no B ever issued for aborted burst.
REQ-025 Stray WVALID in IDLE for 3 cycles -> WREADY=0, counter 0; subsequent AWLEN=1 burst completes with LEN_ERR_SD=0.

Source files
------------

// File: rtl/default_slave_wr.sv
// Default (decode-miss) write slave: accepts any AW/W burst, discards the data
// and answers with DECERR, flagging bursts whose beat count differs from AWLEN+1.
module default_slave_wr (
    input  logic       ACLK,
    input  logic       ARESET,
    input  logic [7:0] AWID_SD,
    input  logic [3:0] AWLEN_SD,
    input  logic       AWVALID_SD,
    output logic       AWREADY_SD,
    input  logic       WLAST_SD,
    input  logic       WVALID_SD,
    output logic       WREADY_SD,
    output logic [7:0] BID_SD,
    output logic [1:0] BRESP_SD,
    output logic       BVALID_SD,
    input  logic       BREADY_SD,
    output logic       LEN_ERR_SD
);

    localparam int unsigned ID_W   = 8;
    localparam int unsigned LEN_W  = 4;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned CMP_W  = CNT_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DATA = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               len_err_q, len_err_d;

    // State and transaction context registers
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= IDLE;
            id_q      <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            len_err_q <= len_err_d;
        end
    end

    // Next-state and context update
    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        len_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (AWVALID_SD) begin
                    id_d    = AWID_SD;
                    len_d   = AWLEN_SD;
                    cnt_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (WVALID_SD) begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (WLAST_SD) begin
                        // Beats seen including this one vs. the announced burst length
                        len_err_d = (CMP_W'(cnt_q) + CMP_W'(1)) != (CMP_W'(len_q) + CMP_W'(1));
                        state_d   = RESP;
                    end
                end
            end
            RESP: begin
                if (BREADY_SD) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign AWREADY_SD = (state_q == IDLE);
    assign WREADY_SD  = (state_q == DATA);
    assign BVALID_SD  = (state_q == RESP);
    assign BID_SD     = id_q;
    assign BRESP_SD   = RESP_DECERR;
    assign LEN_ERR_SD = len_err_q;

endmodule
